pwm_dp: RTL

PWM_DP -- requirements
Module: pwm_dp

---
 rtl/pwm_dp_pkg.sv | 27 ++
 rtl/pwm_cfg_shadow.sv | 49 ++++
 rtl/pwm_dp.sv | 74 +++++++
 3 files changed

// File: rtl/pwm_dp_pkg.sv
// Shared constants, control-unit state names and the configuration rule
// for the PWM datapath and its companion control unit.
package pwm_dp_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int RELOAD_OFS = 2;

  typedef enum logic [1:0] {
    CU_IDLE,
    CU_RELOAD,
    CU_LOW,
    CU_HIGH
  } cu_state_t;

  // Callers zero-extend; the 33-bit compare cannot overflow.
  function automatic logic cfg_ok(
    input logic [31:0] period,
    input logic [31:0] duty
  );
    logic [32:0] p;
    logic [32:0] lim;
    p   = {1'b0, period};
    lim = {1'b0, duty} + 33'(RELOAD_OFS);
    return (duty != 32'd0) && (p >= lim);
  endfunction

endpackage

// File: rtl/pwm_cfg_shadow.sv
// Shadow period/duty slot with pending flag, validity check and
// a one-cycle reject pulse.
module pwm_cfg_shadow
  import pwm_dp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             cfg_err,
  input  logic             commit,
  output logic [WIDTH-1:0] shadow_period,
  output logic [WIDTH-1:0] shadow_duty,
  output logic             pending
);

  logic xfer;
  logic ok;

  assign cfg_ready = !pending;
  assign xfer      = cfg_valid && !pending;
  assign ok        = cfg_ok(32'(cfg_period),
                            32'(cfg_duty));

  // Commit needs pending=1 and a transfer needs pending=0,
  // so the two never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_period <= '0;
      shadow_duty   <= '0;
      pending       <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      cfg_err <= xfer && !ok;
      if (xfer && ok) begin
        shadow_period <= cfg_period;
        shadow_duty   <= cfg_duty;
        pending       <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_dp.sv
// PWM datapath: active period/duty registers, down counter and
// compare flags for an external control unit.
module pwm_dp
  import pwm_dp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             cfg_err,
  input  logic             loadReg,
  input  logic             loadCNT,
  output logic             isEq0,
  output logic             isEq1,
  output logic [WIDTH-1:0] period_q,
  output logic [WIDTH-1:0] duty_q
);

  logic [WIDTH-1:0] shadow_period;
  logic [WIDTH-1:0] shadow_duty;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] eff_period;
  logic             pending;
  logic             commit;

  pwm_cfg_shadow #(.WIDTH(WIDTH)) u_shadow (
    .clk           (clk),
    .rst_n         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_period    (cfg_period),
    .cfg_duty      (cfg_duty),
    .cfg_err       (cfg_err),
    .commit        (commit),
    .shadow_period (shadow_period),
    .shadow_duty   (shadow_duty),
    .pending       (pending)
  );

  assign commit = pending && (loadReg || loadCNT);

  // A reload on a commit edge must see the new pair.
  assign eff_period = commit ? shadow_period : period_q;

  assign isEq0 = (count == '0);
  assign isEq1 = (count == duty_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q <= WIDTH'(RELOAD_OFS);
      duty_q   <= '0;
    end else if (commit) begin
      period_q <= shadow_period;
      duty_q   <= shadow_duty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (loadCNT) begin
      count <= eff_period - WIDTH'(RELOAD_OFS);
    end else if (loadReg) begin
      count <= count;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule
